// File: rtl/instr_loader_if.sv
// Byte-stream and memory-write bundle for the instruction loader.
// The slave side is the loader itself; the master side is whoever
// supplies the program image and observes the memory write port.
interface instr_loader_if #(
  parameter int ADDR_W = 6
);
  logic              start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_last;
  logic              byte_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [ADDR_W:0]   word_count;
  logic              busy;
  logic              done;
  logic              error;

  modport slave (
    input  start, byte_valid, byte_data, byte_last,
    output byte_ready, wr_en, wr_addr, wr_data, word_count, busy, done, error
  );

  modport master (
    output start, byte_valid, byte_data, byte_last,
    input  byte_ready, wr_en, wr_addr, wr_data, word_count, busy, done, error
  );
endinterface

// File: rtl/instr_loader.sv
// Instruction memory loader: packs an MSB-first byte stream into 32-bit
// words and writes them to consecutive word addresses starting at 0.
// busy stays high for the whole load so the core remains stalled until
// the image is complete; done/error report how the load ended.
module instr_loader #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  instr_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [23:0]       shift_q, shift_d;
  logic              last_q, last_d;
  logic              ready_q, ready_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  // Next-state and next-output logic; every output is registered so the
  // values seen on the bus always match the state they belong to.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    last_d    = last_q;
    ready_d   = ready_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    count_d   = count_q;
    busy_d    = busy_q;
    done_d    = done_q;
    error_d   = error_q;

    case (state_q)
      // start is only honoured once the previous load has ended; a restart
      // from DONE or ERR behaves exactly like one from IDLE.
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (bus.start) begin
          state_d = ST_LOAD;
          idx_d   = 2'd0;
          shift_d = '0;
          last_d  = 1'b0;
          count_d = '0;
          ready_d = 1'b1;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          error_d = 1'b0;
        end
      end

      ST_LOAD: begin
        if (bus.byte_valid && ready_q) begin
          shift_d = {shift_q[15:0], bus.byte_data};
          idx_d   = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            // Fourth byte completes the word; the write happens next cycle.
            state_d   = ST_WRITE;
            ready_d   = 1'b0;
            wr_en_d   = 1'b1;
            wr_addr_d = count_q[ADDR_W-1:0];
            wr_data_d = {shift_q, bus.byte_data};
            shift_d   = '0;
            last_d    = bus.byte_last;
          end else if (bus.byte_last) begin
            // Image ends mid-word: drop the fragment and flag it.
            state_d = ST_ERR;
            ready_d = 1'b0;
            busy_d  = 1'b0;
            error_d = 1'b1;
          end
        end
      end

      ST_WRITE: begin
        count_d = count_q + (ADDR_W+1)'(1);
        if (last_q || (count_d == (ADDR_W+1)'(DEPTH))) begin
          // Either the image ended on a word boundary or memory is full.
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = ST_LOAD;
          ready_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        error_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= 2'd0;
      shift_q   <= '0;
      last_q    <= 1'b0;
      ready_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      last_q    <= last_d;
      ready_q   <= ready_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign bus.byte_ready = ready_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.word_count = count_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader. Two instances share one stimulus set:
// a full-size memory for most scenarios and a 4-word memory for the
// capacity scenario; useSmall picks which one is driven and observed.
module tb_instr_loader;

  logic       clk = 1'b0;
  logic       rstN;
  logic       start;
  logic       byteValid;
  logic [7:0] byteData;
  logic       byteLast;
  logic       useSmall;

  logic        obsReady, obsWrEn, obsBusy, obsDone, obsError;
  logic [5:0]  obsWrAddr;
  logic [31:0] obsWrData;
  logic [6:0]  obsCount;

  int vectors    = 0;
  int miscompares = 0;
  int waits;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
  } wrRec_t;
  wrRec_t writes[$];

  logic [7:0] img [8];

  instr_loader_if #(.ADDR_W(6)) bigIf ();
  instr_loader_if #(.ADDR_W(6)) smallIf ();

  instr_loader #(.DEPTH(64), .ADDR_W(6)) dutBig (
    .clk   (clk),
    .rst_n (rstN),
    .bus   (bigIf)
  );

  instr_loader #(.DEPTH(4), .ADDR_W(6)) dutSmall (
    .clk   (clk),
    .rst_n (rstN),
    .bus   (smallIf)
  );

  assign bigIf.start        = start && !useSmall;
  assign bigIf.byte_valid   = byteValid && !useSmall;
  assign bigIf.byte_data    = byteData;
  assign bigIf.byte_last    = byteLast;
  assign smallIf.start      = start && useSmall;
  assign smallIf.byte_valid = byteValid && useSmall;
  assign smallIf.byte_data  = byteData;
  assign smallIf.byte_last  = byteLast;

  assign obsReady  = useSmall ? smallIf.byte_ready : bigIf.byte_ready;
  assign obsWrEn   = useSmall ? smallIf.wr_en      : bigIf.wr_en;
  assign obsWrAddr = useSmall ? smallIf.wr_addr    : bigIf.wr_addr;
  assign obsWrData = useSmall ? smallIf.wr_data    : bigIf.wr_data;
  assign obsCount  = useSmall ? smallIf.word_count : bigIf.word_count;
  assign obsBusy   = useSmall ? smallIf.busy       : bigIf.busy;
  assign obsDone   = useSmall ? smallIf.done       : bigIf.done;
  assign obsError  = useSmall ? smallIf.error      : bigIf.error;

  // 10 ns clock; rising edge is the active edge.
  always #5 clk = ~clk;

  // Capture every memory write on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (obsWrEn === 1'b1) writes.push_back('{addr: obsWrAddr, data: obsWrData});
  end

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offer one byte and hold it until the loader takes it; waitCount reports
  // how many cycles the byte sat without byte_ready.
  task automatic applyStimulus(input logic [7:0] data, input logic last,
                               input int gap, output int waitCount);
    bit seen = 1'b0;
    waitCount = 0;
    byteData  = data;
    byteLast  = last;
    byteValid = 1'b1;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (obsReady === 1'b1) seen = 1'b1;
      else waitCount++;
    end
    if (!seen) checkOutput("readyTimeout", {31'b0, obsReady}, 32'd1);
    @(posedge clk); #1;
    byteValid = 1'b0;
    byteLast  = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic checkWrite(input string tag, input int idx,
                            input logic [5:0] addr, input logic [31:0] data);
    if (idx < writes.size()) begin
      checkOutput({tag, "Addr"}, {26'b0, writes[idx].addr}, {26'b0, addr});
      checkOutput({tag, "Data"}, writes[idx].data, data);
    end
  endtask

  initial begin
    rstN = 1'b0; start = 1'b0; byteValid = 1'b0; byteData = 8'h00;
    byteLast = 1'b0; useSmall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstReady", {31'b0, obsReady}, 32'd0);
    checkOutput("rstBusy",  {31'b0, obsBusy},  32'd0);
    checkOutput("rstDone",  {31'b0, obsDone},  32'd0);
    checkOutput("rstError", {31'b0, obsError}, 32'd0);
    checkOutput("rstCount", {25'b0, obsCount}, 32'd0);
    rstN = 1'b1;
    @(posedge clk); #1;

    // Normal two-word load
    img = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07};
    writes.delete();
    pulseStart();
    checkOutput("t1BusyStart", {31'b0, obsBusy}, 32'd1);
    for (int i = 0; i < 8; i++) applyStimulus(img[i], (i == 7), 0, waits);
    checkOutput("t1BusyWrite", {31'b0, obsBusy}, 32'd1);
    checkOutput("t1WrEn", {31'b0, obsWrEn}, 32'd1);
    @(posedge clk); #1;
    checkOutput("t1BusyFall", {31'b0, obsBusy}, 32'd0);
    checkOutput("t1Done", {31'b0, obsDone}, 32'd1);
    checkOutput("t1Error", {31'b0, obsError}, 32'd0);
    checkOutput("t1Count", {25'b0, obsCount}, 32'd2);
    checkOutput("t1NumWrites", writes.size(), 32'd2);
    checkWrite("t1W0", 0, 6'd0, 32'h20080005);
    checkWrite("t1W1", 1, 6'd1, 32'h20090007);

    // Handshake gaps, plus a byte presented during the WRITE cycle
    writes.delete();
    pulseStart();
    checkOutput("t2DoneCleared", {31'b0, obsDone}, 32'd0);
    checkOutput("t2CountCleared", {25'b0, obsCount}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(img[i], (i == 7), ((i == 3) || (i == 7)) ? 0 : 3, waits);
      if (i == 3) begin
        checkOutput("t2ReadyInWrite", {31'b0, obsReady}, 32'd0);
        checkOutput("t2WrEnInWrite", {31'b0, obsWrEn}, 32'd1);
      end
      if (i == 4) checkOutput("t2HeldByteWaits", waits, 32'd1);
    end
    @(posedge clk); #1;
    checkOutput("t2Done", {31'b0, obsDone}, 32'd1);
    checkOutput("t2Count", {25'b0, obsCount}, 32'd2);
    checkOutput("t2NumWrites", writes.size(), 32'd2);
    checkWrite("t2W0", 0, 6'd0, 32'h20080005);
    checkWrite("t2W1", 1, 6'd1, 32'h20090007);

    // Truncated image ends in ERR with nothing written
    writes.delete();
    pulseStart();
    applyStimulus(8'hAA, 1'b0, 0, waits);
    applyStimulus(8'hBB, 1'b0, 0, waits);
    applyStimulus(8'hCC, 1'b1, 0, waits);
    checkOutput("t3Error", {31'b0, obsError}, 32'd1);
    checkOutput("t3Done", {31'b0, obsDone}, 32'd0);
    checkOutput("t3Busy", {31'b0, obsBusy}, 32'd0);
    checkOutput("t3Count", {25'b0, obsCount}, 32'd0);
    @(posedge clk); #1;
    checkOutput("t3NumWrites", writes.size(), 32'd0);
    checkOutput("t3ErrorHeld", {31'b0, obsError}, 32'd1);

    // Fill a 4-word memory; trailing bytes must be refused
    useSmall = 1'b1;
    writes.delete();
    pulseStart();
    for (int i = 0; i < 16; i++) applyStimulus(8'(i), 1'b0, 0, waits);
    @(posedge clk); #1;
    checkOutput("t4Done", {31'b0, obsDone}, 32'd1);
    checkOutput("t4Busy", {31'b0, obsBusy}, 32'd0);
    checkOutput("t4Count", {25'b0, obsCount}, 32'd4);
    for (int k = 16; k < 20; k++) begin
      byteData  = 8'(k);
      byteValid = 1'b1;
      repeat (2) begin
        @(negedge clk);
        checkOutput("t4ReadyAfterFull", {31'b0, obsReady}, 32'd0);
        @(posedge clk); #1;
      end
    end
    byteValid = 1'b0;
    checkOutput("t4NumWrites", writes.size(), 32'd4);
    for (int w = 0; w < 4; w++)
      checkWrite("t4W", w, 6'(w),
                 {8'(4*w), 8'(4*w+1), 8'(4*w+2), 8'(4*w+3)});
    checkOutput("t4CountHeld", {25'b0, obsCount}, 32'd4);
    useSmall = 1'b0;

    // Reset in the middle of a word
    writes.delete();
    pulseStart();
    applyStimulus(8'h55, 1'b0, 0, waits);
    applyStimulus(8'h66, 1'b0, 0, waits);
    rstN = 1'b0;
    @(posedge clk); #1;
    checkOutput("t5Ready", {31'b0, obsReady}, 32'd0);
    checkOutput("t5WrEn", {31'b0, obsWrEn}, 32'd0);
    checkOutput("t5Busy", {31'b0, obsBusy}, 32'd0);
    checkOutput("t5Done", {31'b0, obsDone}, 32'd0);
    checkOutput("t5Error", {31'b0, obsError}, 32'd0);
    checkOutput("t5WrAddr", {26'b0, obsWrAddr}, 32'd0);
    checkOutput("t5WrData", obsWrData, 32'd0);
    checkOutput("t5Count", {25'b0, obsCount}, 32'd0);
    rstN = 1'b1;
    @(posedge clk); #1;
    pulseStart();
    applyStimulus(8'h11, 1'b0, 0, waits);
    applyStimulus(8'h22, 1'b0, 0, waits);
    applyStimulus(8'h33, 1'b0, 0, waits);
    applyStimulus(8'h44, 1'b1, 0, waits);
    @(posedge clk); #1;
    checkOutput("t5NumWrites", writes.size(), 32'd1);
    checkWrite("t5W0", 0, 6'd0, 32'h11223344);
    checkOutput("t5DoneAfter", {31'b0, obsDone}, 32'd1);
    checkOutput("t5CountAfter", {25'b0, obsCount}, 32'd1);

    // start ignored in LOAD and WRITE, honoured after DONE
    img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    writes.delete();
    pulseStart();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(img[i], (i == 7), 0, waits);
      if (i == 1) begin
        pulseStart();
        checkOutput("t6BusyAfterLoadStart", {31'b0, obsBusy}, 32'd1);
      end
      if (i == 3) begin
        pulseStart();
        checkOutput("t6CountAfterWriteStart", {25'b0, obsCount}, 32'd1);
        checkOutput("t6ReadyAfterWriteStart", {31'b0, obsReady}, 32'd1);
      end
    end
    @(posedge clk); #1;
    checkOutput("t6Done", {31'b0, obsDone}, 32'd1);
    checkOutput("t6Count", {25'b0, obsCount}, 32'd2);
    checkOutput("t6NumWrites", writes.size(), 32'd2);
    checkWrite("t6W0", 0, 6'd0, 32'h01020304);
    checkWrite("t6W1", 1, 6'd1, 32'h05060708);
    writes.delete();
    pulseStart();
    checkOutput("t6RestartDone", {31'b0, obsDone}, 32'd0);
    checkOutput("t6RestartCount", {25'b0, obsCount}, 32'd0);
    checkOutput("t6RestartBusy", {31'b0, obsBusy}, 32'd1);
    applyStimulus(8'hAB, 1'b0, 0, waits);
    applyStimulus(8'hCD, 1'b0, 0, waits);
    applyStimulus(8'hEF, 1'b0, 0, waits);
    applyStimulus(8'h01, 1'b1, 0, waits);
    @(posedge clk); #1;
    checkOutput("t6NumWrites2", writes.size(), 32'd1);
    checkWrite("t6R0", 0, 6'd0, 32'hABCDEF01);
    checkOutput("t6Done2", {31'b0, obsDone}, 32'd1);
    checkOutput("t6Error2", {31'b0, obsError}, 32'd0);
    checkOutput("t6Count2", {25'b0, obsCount}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Fills the instruction memory that the instruction fetch path reads by word-indexed pc.
- Accepts a byte stream over a valid/ready handshake and packs bytes MSB-first into 32-bit words.
- Writes each completed word to the memory write port at consecutive word addresses starting at 0.
- Holds busy while loading so the core stays stalled until the program image is complete.

Parameters:
DEPTH, 64, number of 32-bit words in instruction memory
ADDR_W, 6, word address width; must satisfy 2^ADDR_W >= DEPTH

Ports:
clk  input  1  single clock; all logic on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  one-cycle pulse that begins a load
byte_valid  input  1  byte_data is valid this cycle
byte_data  input  8  next image byte
byte_last  input  1  qualifies the current byte as the final byte of the image
byte_ready  output  1  loader accepts a byte this cycle
wr_en  output  1  memory write strobe, one cycle per word
wr_addr  output  ADDR_W  word address of the write
wr_data  output  32  packed instruction word
word_count  output  ADDR_W+1  words written since start
busy  output  1  load in progress
done  output  1  load completed cleanly; held until next start
error  output  1  malformed image; held until next start

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low, rst_n.
- Reset (rst_n low at a clock edge, including mid-load or mid-write):
  - State returns to IDLE.
  - byte_ready, wr_en, busy, done and error = 0.
  - wr_addr, wr_data, word_count = 0; byte index and shift register cleared.
  - A partially assembled word is discarded.
- States: IDLE, LOAD, WRITE, DONE, ERR.
- IDLE:
  - byte_ready = 0.
  - start moves to LOAD, clears word_count and the byte index, and clears done/error.
- LOAD:
  - byte_ready = 1, busy = 1.
  - A byte is accepted when byte_valid && byte_ready.
  - Bytes pack MSB-first: first byte -> [31:24], second -> [23:16], third -> [15:8], fourth -> [7:0]. The byte index is 2 bits and wraps 3 -> 0.
  - When the 4th byte of a word is accepted, go to WRITE.
  - Accepting byte_last with byte index != 3 goes to ERR; no partial word is written.
- WRITE (exactly one cycle):
  - wr_en = 1, wr_addr = word_count[ADDR_W-1:0], wr_data = assembled word.
  - byte_ready = 0, busy = 1.
  - word_count increments at the end of this cycle.
  - Write latency: wr_en is asserted the cycle after the 4th byte is accepted.
  - Next state is DONE if the word's 4th byte carried byte_last, or if word_count+1 == DEPTH. Otherwise next state is LOAD.
- DONE:
  - done = 1, busy = 0, byte_ready = 0.
  - Memory full without byte_last is a clean DONE.
  - Bytes offered after this point are never accepted, so overflow is impossible.
- ERR:
  - error = 1, busy = 0, byte_ready = 0.
  - word_count retains the number of whole words already written.
- start:
  - Honoured only in IDLE, DONE and ERR; in DONE/ERR it restarts exactly as from IDLE.
  - Ignored in LOAD and WRITE.
- byte_valid held without ready: the byte is held by the source, not consumed. Bubbles in byte_valid are allowed anywhere.
- wr_addr and wr_data hold their last values when wr_en = 0.
- done and error are never asserted together.

Test Plan:
1. Normal two-word load:
   - Stimulus: start, then bytes 20 08 00 05 20 09 00 07, byte_last on the 8th.
   - Response: wr_en at addr 0 with 0x20080005, then addr 1 with 0x20090007; done = 1, word_count = 2, busy falls the cycle after the 2nd write.
2. Handshake gaps:
   - Stimulus: same image with byte_valid low for 3 cycles between every byte.
   - Response: identical writes; byte_ready = 0 in each WRITE cycle, and a byte presented then is accepted the following cycle.
3. Truncated image:
   - Stimulus: start, bytes AA BB CC with byte_last on CC.
   - Response: no wr_en; error = 1, done = 0, word_count = 0.
4. Fill to capacity:
   - Stimulus: DEPTH = 4, 20 bytes with no byte_last.
   - Response: 4 writes at addr 0..3, done after the 4th write, byte_ready stays 0 for the remaining 4 bytes, word_count = 4.
5. Reset mid-word:
   - Stimulus: rst_n low after 2 bytes accepted, then start and bytes 11 22 33 44 with byte_last.
   - Response: all outputs 0 the cycle after reset; a single write at addr 0 with 0x11223344.
6. start handling:
   - Stimulus: start pulsed during LOAD, then again after done.
   - Response: the LOAD-time pulse has no effect (word_count keeps counting); the post-done pulse clears done, sets word_count = 0, and the next write targets addr 0.
